tx_pkt_builder: RTL

- Transmit-side counterpart of the Rx frame-memory path. It holds one 12-bit frame buffer of 480 lines × 80 words (0x9600 words).
- It slices the buffer into one packet per line: a 32-bit frame-sync word, a 16-bit line start address, then 80 words packed as 120 bytes.
- Packets leave as a byte stream with a valid/ready handshake, toward the CC1200 TX FIFO/SPI feeder.
- The sync word alternates per frame, so the receiver's frame-sync correlators can tell consecutive frames apart.

---
 rtl/tx_pkt_pkg.sv | 16 +
 rtl/tx_frame_mem.sv | 20 ++
 rtl/tx_pkt_builder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tx_pkt_pkg.sv
// tx_pkt_pkg: shared states and constants for the Tx packet builder.
// The sync words are also used by the Rx frame-sync correlators.
package tx_pkt_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, ADDR, FETCH, DATA, CHK, END, GAP} state_t;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] FRAME_WORDS = 16'h9600;
  localparam int LINE_WORDS = 80;
  localparam int NUM_LINES = 480;
  localparam int GAP_CYCLES = 16;
  localparam int HDR_BYTES = 6;
  localparam logic [31:0] SYNC0 = 32'h93aaaade;
  localparam logic [31:0] SYNC1 = 32'h935555de;
  function automatic logic [23:0] pack_pair(input logic [11:0] a, input logic [11:0] b);
    return {a, b};
  endfunction
endpackage

// File: rtl/tx_frame_mem.sv
// tx_frame_mem: one frame of 12-bit words, single-clock dual-port, read-first, 1-cycle read latency.
module tx_frame_mem
  import tx_pkt_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [11:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [11:0]       o_rdata
);
  localparam int DEPTH = int'(FRAME_WORDS);
  logic [11:0] r_mem [DEPTH];
  logic [11:0] r_rdata;
  always_ff @(posedge i_clk) begin
    if (i_we && i_waddr < FRAME_WORDS) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/tx_pkt_builder.sv
// tx_pkt_builder: slices the frame buffer into one sync+address+data packet per line on a valid/ready byte stream.
// Define TX_PKT_CHKSUM_EN to append an XOR checksum byte to each packet.
module tx_pkt_builder #(
  parameter int          LINE_WORDS = tx_pkt_pkg::LINE_WORDS,
  parameter int          NUM_LINES  = tx_pkt_pkg::NUM_LINES,
  parameter int          GAP_CYCLES = tx_pkt_pkg::GAP_CYCLES,
  parameter logic [31:0] SYNC0      = tx_pkt_pkg::SYNC0,
  parameter logic [31:0] SYNC1      = tx_pkt_pkg::SYNC1
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        WrEn,
  input  logic [15:0] WrAdd,
  input  logic [11:0] WrData,
  input  logic        TxEnable,
  output logic [7:0]  TxByte,
  output logic        TxValid,
  input  logic        TxReady,
  output logic        TxPktStart,
  output logic        TxPktEnd,
  output logic        FrameSel,
  output logic [8:0]  LineNum,
  output logic        Busy
);
  import tx_pkt_pkg::*;
  state_t            r_state, w_nxt;
  logic [7:0]        r_cnt;
  logic [5:0]        r_grp;
  logic [8:0]        r_line;
  logic              r_frame;
  logic [11:0]       r_a, r_b, w_rdata;
  logic [ADDR_W-1:0] w_base, w_raddr;
  logic [31:0]       w_sync, w_sync_sh;
  logic [23:0]       w_pair;
  logic [7:0]        w_chk;
  logic              w_xfer, w_step, w_last, w_sel, w_line_last;
  assign w_base      = ADDR_W'(32'(r_line) * LINE_WORDS);
  assign w_sel       = r_cnt == 8'd1;
  assign w_raddr     = w_base + {9'd0, r_grp, w_sel};
  assign w_last      = r_grp == 6'(LINE_WORDS / 2 - 1);
  assign w_line_last = r_line == 9'(NUM_LINES - 1);
  assign w_xfer      = TxValid && TxReady;
  // byte-carrying states count transfers, FETCH and GAP count cycles
  assign w_step      = TxValid ? TxReady : (r_state == FETCH || r_state == GAP);
  assign w_sync      = r_frame ? SYNC1 : SYNC0;
  assign w_sync_sh   = w_sync << {r_cnt[1:0], 3'b000};
  assign w_pair      = pack_pair(r_a, r_b);
  tx_frame_mem u_mem (
    .i_clk  (Cclk),
    .i_we   (WrEn),
    .i_waddr(WrAdd),
    .i_wdata(WrData),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
`ifdef TX_PKT_CHKSUM_EN
  localparam state_t TAIL = CHK;
  logic [7:0] r_chk;
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) r_chk <= '0;
    else if (r_state == SYNC) r_chk <= '0;
    else if (r_state == DATA && w_xfer) r_chk <= r_chk ^ TxByte;
  end
  assign w_chk    = r_chk;
  assign TxPktEnd = r_state == CHK;
`else
  localparam state_t TAIL = END;
  assign w_chk    = '0;
  assign TxPktEnd = r_state == DATA && r_cnt == 8'd2 && w_last;
`endif
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = TxEnable ? SYNC : IDLE;
      SYNC:    w_nxt = (w_xfer && r_cnt == 8'd3) ? ADDR : SYNC;
      ADDR:    w_nxt = (w_xfer && r_cnt == 8'd1) ? FETCH : ADDR;
      FETCH:   w_nxt = (r_cnt == 8'd2) ? DATA : FETCH;
      DATA:    if (w_xfer && r_cnt == 8'd2) w_nxt = w_last ? TAIL : FETCH;
      CHK:     w_nxt = w_xfer ? END : CHK;
      END:     w_nxt = GAP;
      GAP:     if (r_cnt == 8'(GAP_CYCLES - 1)) w_nxt = TxEnable ? SYNC : IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_grp   <= '0;
      r_line  <= '0;
      r_frame <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_cnt <= (w_nxt != r_state) ? 8'd0 : r_cnt + {7'd0, w_step};
      if (r_state == END) r_grp <= '0;
      else if (r_state == DATA && w_nxt != DATA) r_grp <= r_grp + 6'd1;
      // read A is issued in cycle 0 and B in cycle 1 of FETCH
      if (r_state == FETCH && r_cnt == 8'd1) r_a <= w_rdata;
      if (r_state == FETCH && r_cnt == 8'd2) r_b <= w_rdata;
      if (r_state == END) begin
        r_line  <= w_line_last ? 9'd0 : r_line + 9'd1;
        r_frame <= r_frame ^ w_line_last;
      end
    end
  end
  always_comb begin
    TxByte = 8'd0;
    case (r_state)
      SYNC:    TxByte = w_sync_sh[31:24];
      ADDR:    TxByte = r_cnt[0] ? w_base[7:0] : w_base[15:8];
      DATA:    TxByte = r_cnt == 8'd0 ? w_pair[23:16] : r_cnt == 8'd1 ? w_pair[15:8] : w_pair[7:0];
      CHK:     TxByte = w_chk;
      default: TxByte = 8'd0;
    endcase
  end
  assign TxValid    = r_state inside {SYNC, ADDR, DATA, CHK};
  assign TxPktStart = r_state == SYNC && r_cnt == 8'd0;
  assign FrameSel   = r_frame;
  assign LineNum    = r_line;
  assign Busy       = r_state != IDLE;
endmodule
